// File: rtl/multdiv_divider.sv
// Signed 32-bit restoring divider: one quotient bit per cycle, result and ready pulse 33 edges after start.
// No backpressure: ctrl_DIV at any time restarts from the new operands, and the aborted divide gives no ready pulse.
module multdiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg;
  logic             dz;

  logic [WIDTH:0]   shifted_rem;
  logic [WIDTH:0]   trial;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  // The remainder never exceeds the divisor magnitude (<= 2^31), so WIDTH bits
  // hold it; the trial is one bit wider so its sign marks a failed subtraction.
  always_comb begin
    shifted_rem = {rem, quo[WIDTH-1]};
    trial       = shifted_rem + {1'b1, ~dvs} + (WIDTH+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      neg            <= 1'b0;
      dz             <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        quo     <= abs_val(data_operandA);
        dvs     <= abs_val(data_operandB);
        rem     <= '0;
        neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz      <= (data_operandB == '0);
        counter <= '0;
        busy    <= 1'b1;
        state   <= RUN;
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            rem     <= trial[WIDTH] ? shifted_rem[WIDTH-1:0] : trial[WIDTH-1:0];
            quo     <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            counter <= counter + 1'b1;
            if (counter == CW'(WIDTH-1)) state <= FIX;
          end
          FIX: begin
            data_result    <= dz ? '0 : (neg ? (~quo + WIDTH'(1)) : quo);
            data_exception <= dz;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
